// File: rtl/loop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loop_sequencer_pkg
// Description : Shared types for the hardware loop sequencer: step operator
//               encoding and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package loop_sequencer_pkg;

   // Step operator applied to the loop index after each accepted beat.
   // RSVD is accepted on the interface and behaves exactly like ADD.
   typedef enum logic [1:0] {
      ADD  = 2'd0,
      MUL  = 2'd1,
      SHL  = 2'd2,
      RSVD = 2'd3
   } step_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : loop_sequencer_pkg
`default_nettype wire

// File: rtl/loop_step_alu.sv
`default_nettype none
// ============================================================================
// Module      : loop_step_alu
// Description : Purely combinational step unit. Computes next = idx op step
//               at full precision and flags any result that does not fit in
//               WIDTH bits.
// Ports       : idx_i   [WIDTH-1:0]  current index
//               step_i  [WIDTH-1:0]  step operand
//               op_i    step_op_t    ADD / MUL / SHL (RSVD acts as ADD)
//               next_o  [WIDTH-1:0]  low WIDTH bits of the result
//               ovf_o                result does not fit in WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module loop_step_alu
   import loop_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] idx_i,
   input  logic [WIDTH-1:0] step_i,
   input  step_op_t         op_i,
   output logic [WIDTH-1:0] next_o,
   output logic             ovf_o
);

   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_prod;
   logic [2*WIDTH-1:0]   w_shl_wide;
   logic [SHW-1:0]       w_sh;
   logic                 w_step_big;

   assign w_sum      = {1'b0, idx_i} + {1'b0, step_i};
   assign w_prod     = {{WIDTH{1'b0}}, idx_i} * {{WIDTH{1'b0}}, step_i};
   assign w_sh       = step_i[SHW-1:0];
   // Shift amounts of WIDTH or more are always overflow, even for idx=0,
   // since the low SHW bits alone would alias to a small legal shift.
   assign w_step_big = ({1'b0, step_i} >= (WIDTH+1)'(WIDTH));
   assign w_shl_wide = {{WIDTH{1'b0}}, idx_i} << w_sh;

   always_comb begin
      next_o = w_sum[WIDTH-1:0];
      ovf_o  = w_sum[WIDTH];
      case (op_i)
         MUL: begin
            next_o = w_prod[WIDTH-1:0];
            ovf_o  = |w_prod[2*WIDTH-1:WIDTH];
         end
         SHL: begin
            next_o = w_shl_wide[WIDTH-1:0];
            ovf_o  = w_step_big | (|w_shl_wide[2*WIDTH-1:WIDTH]);
         end
         default: begin
            next_o = w_sum[WIDTH-1:0];
            ovf_o  = w_sum[WIDTH];
         end
      endcase
   end

endmodule : loop_step_alu
`default_nettype wire

// File: rtl/loop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : loop_sequencer
// Description : Hardware loop controller. Emits the index stream of
//               for (i = init; i < limit; i op= step) as a valid/ready
//               stream, one index per beat, and reports overflowing or
//               non-progressing loops through a sticky error flag.
//               Optional build macro LOOP_SEQUENCER_COUNT_EN adds o_count,
//               the number of accepted beats of the current/last loop.
// Ports       : i_clk, i_rst (async, active-high)
//               i_start, i_abort         control
//               i_init, i_limit, i_step  loop config, sampled at start
//               i_step_op                0=ADD 1=MUL 2=SHL 3=ADD
//               o_valid/i_ready, o_index, o_last  index stream
//               o_busy, o_done, o_error  status
//               o_count                  (LOOP_SEQUENCER_COUNT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module loop_sequencer
   import loop_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_init,
   input  logic [WIDTH-1:0] i_limit,
   input  logic [WIDTH-1:0] i_step,
   input  logic [1:0]       i_step_op,
   output logic             o_busy,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_index,
   output logic             o_last,
   output logic             o_done,
   output logic             o_error
`ifdef LOOP_SEQUENCER_COUNT_EN
   ,
   output logic [WIDTH-1:0] o_count
`endif
);

   state_t           state_q;
   logic [WIDTH-1:0] idx_q;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] step_q;
   step_op_t         op_q;
   logic             err_q;

   logic [WIDTH-1:0] next_d;
   logic             ovf_d;
   logic             stall_d;
   logic             hs_d;

   loop_step_alu #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_alu (
      .idx_i  (idx_q),
      .step_i (step_q),
      .op_i   (op_q),
      .next_o (next_d),
      .ovf_o  (ovf_d)
   );

   // A step that fails to move the index forward would loop forever.
   assign stall_d = ovf_d | (next_d <= idx_q);
   assign hs_d    = (state_q == RUN) & i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         limit_q <= '0;
         step_q  <= '0;
         op_q    <= ADD;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  idx_q   <= i_init;
                  limit_q <= i_limit;
                  step_q  <= i_step;
                  op_q    <= step_op_t'(i_step_op);
                  err_q   <= 1'b0;
                  state_q <= (i_init < i_limit) ? RUN : DONE;
               end
            end
            RUN: begin
               // Abort wins over a same-cycle handshake: the index is not
               // advanced and the error flag is left untouched.
               if (i_abort) begin
                  state_q <= DONE;
               end else if (hs_d) begin
                  if (stall_d) begin
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else if (next_d >= limit_q) begin
                     state_q <= DONE;
                  end else begin
                     idx_q <= next_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef LOOP_SEQUENCER_COUNT_EN
   logic [WIDTH-1:0] count_q;

   // The consumer took the beat even when abort blocks the advance, so
   // every handshake is counted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else if ((state_q == IDLE) && i_start) begin
         count_q <= '0;
      end else if (hs_d) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign o_count = count_q;
`else
   // Beat counter not built.
`endif

   assign o_busy  = (state_q != IDLE);
   assign o_valid = (state_q == RUN);
   assign o_done  = (state_q == DONE);
   assign o_index = idx_q;
   assign o_error = err_q;
   assign o_last  = o_valid & (stall_d | (next_d >= limit_q));

endmodule : loop_sequencer
`default_nettype wire

// File: tb/tb_loop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_loop_sequencer
// Description : Self-checking bench for loop_sequencer. Table of loop
//               configurations with hand-computed index streams, plus
//               directed sequences for stalls, abort and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort_s;
   logic [31:0] init_v;
   logic [31:0] limit_v;
   logic [31:0] step_v;
   logic [1:0]  op_v;
   logic        busy;
   logic        valid;
   logic        ready;
   logic [31:0] index;
   logic        last;
   logic        done;
   logic        error;
`ifdef LOOP_SEQUENCER_COUNT_EN
   logic [31:0] count;
`endif

   int pass_cnt = 0;
   int total    = 0;

   loop_sequencer #(.WIDTH(32)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_abort   (abort_s),
      .i_init    (init_v),
      .i_limit   (limit_v),
      .i_step    (step_v),
      .i_step_op (op_v),
      .o_busy    (busy),
      .o_valid   (valid),
      .i_ready   (ready),
      .o_index   (index),
      .o_last    (last),
      .o_done    (done),
      .o_error   (error)
`ifdef LOOP_SEQUENCER_COUNT_EN
      ,
      .o_count   (count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] init;
      logic [31:0] limit;
      logic [31:0] step;
      int          n;
      logic        err;
      logic [31:0] idx [12];
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic begin_loop(input logic [1:0] op, input logic [31:0] ini,
                             input logic [31:0] lim, input logic [31:0] stp);
      @(negedge clk);
      op_v    = op;
      init_v  = ini;
      limit_v = lim;
      step_v  = stp;
      start   = 1'b1;
   endtask

   task automatic run_vec(input int k);
      int  beats;
      bit  seen_done;
      beats     = 0;
      seen_done = 0;
      ready     = 1'b1;
      begin_loop(vecs[k].op, vecs[k].init, vecs[k].limit, vecs[k].step);
      for (int c = 0; c < 200 && !seen_done; c++) begin
         @(negedge clk);
         start = 1'b0;
         // Scramble config after start; it must have been latched.
         init_v  = 32'hDEAD_BEEF;
         limit_v = 32'h0;
         if (valid) begin
            chk($sformatf("v%0d idx%0d", k, beats), index,
                (beats < 12) ? vecs[k].idx[beats] : 32'hxxxx_xxxx);
            chk($sformatf("v%0d last%0d", k, beats), {31'd0, last},
                (beats == vecs[k].n - 1) ? 32'd1 : 32'd0);
            beats++;
         end else if (done) begin
            seen_done = 1;
            chk($sformatf("v%0d err", k), {31'd0, error}, {31'd0, vecs[k].err});
            chk($sformatf("v%0d busy_done", k), {31'd0, busy}, 32'd1);
`ifdef LOOP_SEQUENCER_COUNT_EN
            chk($sformatf("v%0d count", k), count, vecs[k].n);
`endif
         end
      end
      if (!seen_done) begin
         total++;
         $display("FAIL v%0d timeout: got no done required done", k);
      end
      chk($sformatf("v%0d beats", k), beats, vecs[k].n);
      @(negedge clk);
      chk($sformatf("v%0d idle", k), {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      // op, init, limit, step, beats, err, indices
      vecs[0] = '{2'd0, 32'd0, 32'd10, 32'd1, 10, 1'b0,
                  '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0}};
      vecs[1] = '{2'd1, 32'd1, 32'd100, 32'd2, 7, 1'b0,
                  '{1, 2, 4, 8, 16, 32, 64, 0, 0, 0, 0, 0}};
      vecs[2] = '{2'd1, 32'd0, 32'd10, 32'd2, 1, 1'b1,
                  '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[3] = '{2'd2, 32'd1, 32'd1000, 32'd40, 1, 1'b1,
                  '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[4] = '{2'd0, 32'd5, 32'd5, 32'd1, 0, 1'b0,
                  '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[5] = '{2'd2, 32'd1, 32'd100, 32'd3, 3, 1'b0,
                  '{1, 8, 64, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[6] = '{2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8, 2, 1'b1,
                  '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[7] = '{2'd0, 32'd2, 32'd10, 32'd0, 1, 1'b1,
                  '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[8] = '{2'd3, 32'd0, 32'd6, 32'd2, 3, 1'b0,
                  '{0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[9] = '{2'd0, 32'd0, 32'd0, 32'd1, 0, 1'b0,
                  '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

      rst = 1'b1; start = 1'b0; abort_s = 1'b0; ready = 1'b0;
      init_v = '0; limit_v = '0; step_v = '0; op_v = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset outs", {27'd0, busy, valid, last, done, error}, 32'd0);
      chk("reset index", index, 32'd0);

      for (int k = 0; k < 10; k++) run_vec(k);

      // Stalling consumer: ready 1,0,0 repeating; index must hold while stalled.
      begin
         logic [31:0] exp_s [4];
         int  hs;
         bit  seen_done;
         exp_s = '{32'd3, 32'd8, 32'd13, 32'd18};
         hs = 0;
         seen_done = 0;
         ready = 1'b0;
         begin_loop(2'd0, 32'd3, 32'd20, 32'd5);
         for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk);
            start = 1'b0;
            ready = (c % 3 == 0);
            if (valid) begin
               chk($sformatf("stall idx c%0d", c), index,
                   (hs < 4) ? exp_s[hs] : 32'hxxxx_xxxx);
               if (ready) begin
                  chk($sformatf("stall last c%0d", c), {31'd0, last},
                      (hs == 3) ? 32'd1 : 32'd0);
                  hs++;
               end
            end else if (done) begin
               seen_done = 1;
            end
         end
         if (!seen_done) begin
            total++;
            $display("FAIL stall timeout: got no done required done");
         end
         chk("stall handshakes", hs, 32'd4);
         ready = 1'b1;
      end

      // Abort on the third beat: no advance, done next cycle, no error.
      begin_loop(2'd0, 32'd0, 32'd100, 32'd1);
      @(negedge clk); start = 1'b0;
      chk("abort beat1", index, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("abort beat3", {31'd0, valid}, 32'd1);
      chk("abort beat3 idx", index, 32'd2);
      abort_s = 1'b1;
      @(negedge clk);
      abort_s = 1'b0;
      chk("abort done", {29'd0, done, valid, error}, 32'b100);
      chk("abort idx held", index, 32'd2);
      @(negedge clk);
      chk("abort idle", {30'd0, busy, valid}, 32'd0);

      // Reset in the middle of a running loop.
      begin_loop(2'd0, 32'd7, 32'd100, 32'd1);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("rst pre idx", index, 32'd8);
      rst = 1'b1;
      #1;
      chk("rst async outs", {27'd0, busy, valid, last, done, error}, 32'd0);
      chk("rst async idx", index, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst quiet c%0d", c), {29'd0, busy, valid, done}, 32'd0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule : tb_loop_sequencer
`default_nettype wire

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Hardware loop controller. Emits the index stream of `for (i = init; i < limit; i op= step)` as a valid/ready stream, one index per beat.
- Supported step operators: add, multiply, shift-left.
- Sits in front of compound-assignment datapaths that are sequenced by loop indices. Catches non-progressing or overflowing loops and reports them instead of hanging.

Parameters:
- WIDTH, 32, width of index, limit and step (unsigned).
- SHW, $clog2(WIDTH), width of the shift amount taken from step for SHL.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  start pulse; accepted only in IDLE.
- i_abort  input  1  terminate the running loop.
- i_init  input  WIDTH  initial index; sampled at start.
- i_limit  input  WIDTH  exclusive upper bound; sampled at start.
- i_step  input  WIDTH  step operand; sampled at start.
- i_step_op  input  2  step operator: 0=ADD, 1=MUL, 2=SHL, 3=reserved (treated as ADD).
- o_busy  output  1  high in RUN and DONE.
- o_valid  output  1  index beat valid.
- i_ready  input  1  consumer accepts the beat.
- o_index  output  WIDTH  current loop index.
- o_last  output  1  qualifies o_valid; final beat.
- o_done  output  1  one-cycle completion pulse.
- o_error  output  1  sticky until next accepted start; set on overflow or non-progress.

Behaviour:
- Reset values: state=IDLE; o_busy, o_valid, o_last, o_done, o_error = 0; o_index = 0; latched config = 0.
- State IDLE:
  - On i_start, latch init/limit/step/op and set idx=init.
  - Clear o_error.
  - Go to RUN if init<limit, else go to DONE (zero iterations).
- State RUN:
  - o_valid=1 and o_index=idx. First beat appears the cycle after start.
  - o_index holds stable while o_valid && !i_ready.
  - On handshake, next = idx op step, computed unsigned at full precision:
    - ADD: WIDTH+1 bits; carry means overflow.
    - MUL: 2*WIDTH bits; any nonzero upper half means overflow.
    - SHL: shift by step[SHW-1:0]; step >= WIDTH, or any 1 shifted out, means overflow.
  - o_last = combinational (overflow || next <= idx || next >= limit), evaluated on the current idx.
  - Handshake with overflow or next<=idx: set o_error, go to DONE. This covers ADD step 0, MUL by 0/1, and SHL by 0.
  - Handshake with next>=limit: go to DONE.
  - Otherwise idx=next, stay in RUN. With i_ready held high, beats are back-to-back at one per cycle.
- State DONE: o_done=1 for exactly one cycle, o_valid=0, then go to IDLE.
- i_abort in RUN: go to DONE next cycle, o_error unchanged.
  - Takes priority over a same-cycle handshake. The beat is still counted as consumed by the consumer; the sequencer performs no advance.
- Ignored inputs:
  - i_start outside IDLE.
  - i_abort outside RUN.
  - Config changes after start.
- i_rst asserted mid-loop: immediate return to reset values; no o_done.
- Comparisons are unsigned. limit=0 always gives zero iterations.

Optional Feature:
- Macro: LOOP_SEQUENCER_COUNT_EN.
- Defined:
  - Adds port o_count, output, WIDTH bits.
  - Cleared on accepted start; increments on each handshake; holds after DONE until next start.
  - Wraps modulo 2^WIDTH.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package loop_sequencer_pkg:
  - step_op_t enum {ADD, MUL, SHL, RSVD}.
  - state_t enum {IDLE, RUN, DONE}.
- Sub-module loop_step_alu: purely combinational (idx, step, op) -> (next, overflow). Instantiated once.
- Top-level loop_sequencer holds the FSM, latched config, handshake and o_last/o_error logic.

Test Plan:
- ADD, init=0, limit=10, step=1, i_ready=1 -> indices 0..9 on consecutive cycles; o_last on 9; o_done one cycle after; o_error=0; o_count=10.
- MUL, init=1, limit=100, step=2 -> 1,2,4,8,16,32,64; o_last on 64; o_done; o_error=0.
- ADD, init=3, limit=20, step=5, i_ready toggling 1-0-0-1... -> 3,8,13,18, each held stable while stalled; exactly 4 handshakes.
- init=5, limit=5 -> no o_valid; o_done the cycle after next; o_busy high 1 cycle.
- MUL, init=0, step=2, limit=10 -> single beat 0 with o_last; o_error=1. SHL, init=1, step=40 (WIDTH=32) -> beat 1, o_error=1.
- i_abort at 3rd beat, then i_rst mid-run on a second loop -> abort gives o_done, no further beats; reset returns all outputs to 0 with no o_done.
